// File: rtl/respondedor_memoria_datos.sv
// Multi-cycle data-memory responder for the MIPS MEM stage: valid/ready requests, WAIT_CYCLES wait states, one-cycle response pulse.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
`timescale 1ns/1ps

module respondedor_memoria_datos #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [31:0] i_address,
  input  logic [31:0] i_din,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [31:0] o_dout,
  output logic        o_busy,
  output logic        o_error
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] din_q;
  logic        write_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             take_req;
  logic             enter_resp;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_din;
  logic             acc_write;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_in_range;
  logic             acc_misalign;
  logic             acc_ok;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the access fields come straight from the inputs while in IDLE.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    take_req   = 1'b0;
    enter_resp = 1'b0;
    acc_addr   = addr_q;
    acc_din    = din_q;
    acc_write  = write_q;
    if (state == IDLE) begin
      take_req  = i_req_valid;
      acc_addr  = i_address;
      acc_din   = i_din;
      acc_write = i_req_write;
      enter_resp = i_req_valid && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      enter_resp = (wait_cnt == 4'd1);
    end
  end

  assign acc_idx      = acc_addr[IDX_W+1:2];
  assign acc_in_range = (acc_addr >> (IDX_W + 2)) == 32'd0;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign acc_misalign = acc_addr[1:0] != 2'b00;
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^acc_addr[1:0];
  assign acc_misalign     = 1'b0;
`endif

  assign acc_ok = acc_in_range && !acc_misalign;

  // NOTE: the storage array has no reset; clearing it would need a per-word reset network and its contents are defined only by stores.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_write && acc_ok) begin
      mem[acc_idx] <= acc_din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      addr_q       <= 32'd0;
      din_q        <= 32'd0;
      write_q      <= 1'b0;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_error      <= 1'b0;
      o_dout       <= 32'd0;
    end else begin
      o_resp_valid <= 1'b0;
      o_error      <= 1'b0;

      if (enter_resp) begin
        o_resp_valid <= 1'b1;
        o_error      <= acc_misalign;
        if (!acc_write) begin
          o_dout <= acc_ok ? mem[acc_idx] : 32'd0;
        end
      end

      case (state)
        IDLE: begin
          if (take_req) begin
            addr_q      <= i_address;
            din_q       <= i_din;
            write_q     <= i_req_write;
            wait_cnt    <= WAIT_INIT;
            o_req_ready <= 1'b0;
            o_busy      <= 1'b1;
            state       <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_respondedor_memoria_datos.sv
// Self-checking bench for respondedor_memoria_datos: table-driven vectors plus hand-written corner sequences,
// with a response scoreboard that checks latency, load data, held o_dout on stores and o_error.
`timescale 1ns/1ps

module tb_respondedor_memoria_datos;

  localparam int DEPTH = 64;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid;
  logic        i_req_write;
  logic [31:0] i_address;
  logic [31:0] i_din;
  logic        o_req_ready;
  logic        o_resp_valid;
  logic [31:0] o_dout;
  logic        o_busy;
  logic        o_error;

  respondedor_memoria_datos #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .i_req_write (i_req_write),
    .i_address   (i_address),
    .i_din       (i_din),
    .o_req_ready (o_req_ready),
    .o_resp_valid(o_resp_valid),
    .o_dout      (o_dout),
    .o_busy      (o_busy),
    .o_error     (o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] dout;
    logic        err;
    int          acc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          resp_count = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_dout = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Response side of the scoreboard: every pulse must match the oldest accepted request.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && o_resp_valid) begin
      resp_count++;
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_latency", cyc - e.acc, WAITC);
        check("resp_error", {31'd0, o_error}, {31'd0, e.err});
        if (e.wr) begin
          check("store_dout_held", o_dout, last_dout);
        end else begin
          check("load_dout", o_dout, e.dout);
          last_dout = e.dout;
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] din,
                      input logic [31:0] exp_dout, input logic exp_err, input bit hold,
                      output int acc);
    int n = 0;
    @(posedge clk); #2;
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_address   = addr;
    i_din       = din;
    @(negedge clk);
    while (!o_req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!o_req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      acc = -1;
      i_req_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      sb.push_back('{wr, exp_dout, exp_err, acc});
      @(posedge clk); #2;
      if (!hold) i_req_valid = 1'b0;
    end
  endtask

  function automatic logic addr_err(input logic [31:0] addr);
`ifdef DMEM_MISALIGN_TRAP_EN
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr < 32'(4 * DEPTH)) && !addr_err(addr);
  endfunction

  task automatic store(input logic [31:0] addr, input logic [31:0] din);
    int acc;
    send(1'b1, addr, din, 32'd0, addr_err(addr), 1'b0, acc);
    if (addr_ok(addr)) model[addr[7:2]] = din;
  endtask

  task automatic load(input logic [31:0] addr);
    int acc;
    send(1'b0, addr, 32'd0, addr_ok(addr) ? model[addr[7:2]] : 32'd0, addr_err(addr), 1'b0, acc);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !o_req_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    int   a1, a2, a3, acc;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0001};
    vecs[6] = '{1'b1, 32'h0000_0010, 32'h0000_0011, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0011};
    vecs[8] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1101_0101};

    reset       = 1'b1;
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    i_address   = 32'd0;
    i_din       = 32'd0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, o_req_ready}, 32'd1);
    check("reset_busy",  {31'd0, o_busy},      32'd0);
    check("reset_resp",  {31'd0, o_resp_valid}, 32'd0);
    check("reset_error", {31'd0, o_error},     32'd0);
    check("reset_dout",  o_dout,               32'd0);

    // Give every word a known value so later sweeps have a defined reference.
    for (int i = 0; i < DEPTH; i++) begin
      store(32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0101_0101);
    end
    wait_idle();

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].exp_dout, 1'b0, 1'b0, acc);
      if (vecs[i].wr) model[vecs[i].addr[7:2]] = vecs[i].din;
    end
    wait_idle();

    // Valid held high across three loads: one acceptance every WAIT_CYCLES+2 cycles.
    send(1'b0, 32'h10, 32'd0, 32'h0000_0011, 1'b0, 1'b1, a1);
    @(negedge clk);
    check("held_busy_mid",  {31'd0, o_busy},      32'd1);
    check("held_ready_mid", {31'd0, o_req_ready}, 32'd0);
    send(1'b0, 32'h10, 32'd0, 32'h0000_0011, 1'b0, 1'b1, a2);
    send(1'b0, 32'h10, 32'd0, 32'h0000_0011, 1'b0, 1'b0, a3);
    check("held_gap_1", a2 - a1, WAITC + 2);
    check("held_gap_2", a3 - a2, WAITC + 2);
    wait_idle();
    repeat (3) @(negedge clk);
    check("dout_held_idle", o_dout, 32'h0000_0011);

    // Out-of-range store is dropped, load returns zero, memory untouched.
    store(32'h100, 32'h0000_1234);
    load(32'h100);
    for (int i = 0; i < DEPTH; i++) load(32'(i * 4));
    wait_idle();

    // Reset while the store to 0x20 is still waiting: it must never commit or respond.
    send(1'b1, 32'h20, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0, acc);
    #1 reset = 1'b1;
    sb.delete();
    last_dout = 32'd0;
    #1;
    check("abort_ready", {31'd0, o_req_ready}, 32'd1);
    check("abort_busy",  {31'd0, o_busy},      32'd0);
    check("abort_dout",  o_dout,               32'd0);
    resp_count = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_resp", resp_count, 32'd0);
    load(32'h20);
    wait_idle();

    // Misaligned store/load to the word at 0x20.
    store(32'h22, 32'h5A5A_0022);
    load(32'h20);
    load(32'h22);
    wait_idle();

    check("all_responses_consumed", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
